recv_timeout_monitor: RTL and testbench



---
 rtl/recv_timeout_monitor.sv | 179 +++++++++++++++++
 tb/tb_recv_timeout_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recv_timeout_monitor.sv
`default_nettype none
// ============================================================================
// Module   : recv_timeout_monitor
// Purpose  : UDP receive-path support block. It provides a programmable-width
//            inactivity timer and an optional post-trigger probe capture
//            buffer for readback.
//            The capture buffer is built only when RECV_MON_CAPTURE_EN is
//            defined. Otherwise cap_armed, cap_done and rd_data are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module recv_timeout_monitor #(
  parameter int TIMER_WIDTH = 12,
  parameter int CAP_AW      = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   timer_clear,
  input  logic                   timer_enable,
  output logic                   timer_out,
  output logic [TIMER_WIDTH-1:0] timer_count,
  input  logic                   cap_arm,
  input  logic [7:0]             probe0,
  input  logic                   probe1,
  input  logic                   probe2,
  input  logic                   probe3,
  input  logic [2:0]             probe4,
  input  logic [15:0]            probe5,
  input  logic [47:0]            probe6,
  input  logic [15:0]            probe7,
  output logic                   cap_armed,
  output logic                   cap_done,
  input  logic [CAP_AW-1:0]      rd_addr,
  output logic [93:0]            rd_data
);

  localparam logic [TIMER_WIDTH-1:0] TMR_ONE = TIMER_WIDTH'(1);

  logic [TIMER_WIDTH-1:0] count_q;
  logic                   tmo_q;

  // Timer: clear dominates enable; the terminal enabled edge wraps to zero
  // and raises a single-cycle timeout pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tmo_q   <= 1'b0;
    end else if (timer_clear) begin
      count_q <= '0;
      tmo_q   <= 1'b0;
    end else if (timer_enable) begin
      if (&count_q) begin
        count_q <= '0;
        tmo_q   <= 1'b1;
      end else begin
        count_q <= count_q + TMR_ONE;
        tmo_q   <= 1'b0;
      end
    end else begin
      tmo_q <= 1'b0;
    end
  end

  assign timer_out   = tmo_q;
  assign timer_count = count_q;

`ifdef RECV_MON_CAPTURE_EN

  localparam int              DEPTH   = 1 << CAP_AW;
  localparam logic [CAP_AW-1:0] PTR_ONE = CAP_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  cap_state_t        state_q;
  logic [CAP_AW-1:0] ptr_q;
  logic              armed_q;
  logic              done_q;
  logic [93:0]       rd_data_q;
  logic [93:0]       mem_q [0:DEPTH-1];

  logic [93:0]       w_sample;
  logic              w_wr_en;

  // Packed probe sample. probe0 occupies the least-significant byte.
  assign w_sample = {probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};

  // The trigger edge writes address 0. The pointer is 0 whenever the FSM sits
  // in ARMED, so one write port addressed by the pointer covers both cases.
  assign w_wr_en = ((state_q == ST_ARMED) && probe1) || (state_q == ST_CAPTURE);

  // Capture memory. It has no reset, and its contents are meaningful only once
  // the capture is done.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[ptr_q] <= w_sample;
    end
  end

  // Capture FSM. Arm requests are ignored while waiting or capturing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cap_arm) begin
            state_q <= ST_ARMED;
            armed_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (probe1) begin
            state_q <= ST_CAPTURE;
            ptr_q   <= PTR_ONE;
          end
        end
        ST_CAPTURE: begin
          if (&ptr_q) begin
            state_q <= ST_DONE;
            ptr_q   <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + PTR_ONE;
          end
        end
        ST_DONE: begin
          if (cap_arm) begin
            state_q <= ST_ARMED;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ptr_q   <= '0;
          armed_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Registered readback. Data appears one cycle after the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign cap_armed = armed_q;
  assign cap_done  = done_q;
  assign rd_data   = rd_data_q;

`else

  // Capture is not built. Its inputs are folded into a sink so that they
  // remain visibly, and intentionally, unused.
  logic unused_cap_inputs;
  assign unused_cap_inputs = ^{cap_arm, probe0, probe1, probe2, probe3,
                               probe4, probe5, probe6, probe7, rd_addr};

  assign cap_armed = 1'b0;
  assign cap_done  = 1'b0;
  assign rd_data   = '0;

`endif

endmodule
`default_nettype wire

// File: tb/tb_recv_timeout_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_recv_timeout_monitor
// Purpose  : Self-checking bench for recv_timeout_monitor (TIMER_WIDTH=4,
//            CAP_AW=3). It compares the DUT against a behavioural model
//            written from the block's rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_recv_timeout_monitor;

  localparam int TW    = 4;
  localparam int AW    = 3;
  localparam int TMAX  = 1 << TW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          timer_clear, timer_enable, timer_out;
  logic [TW-1:0] timer_count;
  logic          cap_arm;
  logic [7:0]    probe0;
  logic          probe1, probe2, probe3;
  logic [2:0]    probe4;
  logic [15:0]   probe5, probe7;
  logic [47:0]   probe6;
  logic          cap_armed, cap_done;
  logic [AW-1:0] rd_addr;
  logic [93:0]   rd_data;

  recv_timeout_monitor #(.TIMER_WIDTH(TW), .CAP_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .timer_clear(timer_clear), .timer_enable(timer_enable),
    .timer_out(timer_out), .timer_count(timer_count),
    .cap_arm(cap_arm),
    .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7),
    .cap_armed(cap_armed), .cap_done(cap_done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int          m_count;
  logic        m_out;
  logic        m_armed, m_done, m_trig;
  int          m_taken;
  logic [93:0] m_mem [DEPTH];
  logic [93:0] m_rd;
  bit          chk_rd = 0;

  task automatic chk(input string tag, input logic [93:0] obs, input logic [93:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [93:0] sample_now();
    return {probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};
  endfunction

  task automatic model_reset();
    m_count = 0; m_out = 0;
    m_armed = 0; m_done = 0; m_trig = 0; m_taken = 0;
    m_rd = '0;
  endtask

  task automatic rand_probes(input logic p1);
    probe0 = 8'($urandom);
    probe1 = p1;
    probe2 = 1'($urandom);
    probe3 = 1'($urandom);
    probe4 = 3'($urandom);
    probe5 = 16'($urandom);
    probe6 = {16'($urandom), $urandom()};
    probe7 = 16'($urandom);
  endtask

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then compare the outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (timer_clear) begin
      m_count = 0; m_out = 0;
    end else if (timer_enable) begin
      m_out   = (m_count == TMAX - 1);
      m_count = (m_count + 1) % TMAX;
    end else begin
      m_out = 0;
    end
`ifdef RECV_MON_CAPTURE_EN
    m_rd = m_mem[rd_addr];
    if (m_armed) begin
      if (!m_trig) begin
        if (probe1) begin
          m_mem[0] = sample_now(); m_taken = 1; m_trig = 1;
        end
      end else begin
        m_mem[m_taken] = sample_now();
        m_taken++;
        if (m_taken == DEPTH) begin
          m_armed = 0; m_done = 1; m_trig = 0;
        end
      end
    end else if (cap_arm) begin
      m_armed = 1; m_done = 0; m_trig = 0; m_taken = 0;
    end
`endif
    #1;
    chk("timer_out", 94'(timer_out), 94'(m_out));
    chk("timer_count", 94'(timer_count), 94'(m_count));
    chk("cap_armed", 94'(cap_armed), 94'(m_armed));
    chk("cap_done", 94'(cap_done), 94'(m_done));
`ifdef RECV_MON_CAPTURE_EN
    if (chk_rd) chk("rd_data", rd_data, m_rd);
`else
    chk("rd_data_tied", rd_data, 94'd0);
`endif
  endtask

  initial begin
    int pulses;
    int first_p, second_p;
    reset = 1; timer_clear = 0; timer_enable = 0; cap_arm = 0; rd_addr = '0;
    rand_probes(1'b0);
    model_reset();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 94'(timer_count), 94'd0);
    chk("rst_out", 94'(timer_out), 94'd0);
    chk("rst_armed", 94'(cap_armed), 94'd0);
    chk("rst_done", 94'(cap_done), 94'd0);
    chk("rst_rd", rd_data, 94'd0);
    reset = 0;

    // Timer test 1: one pulse after the 16th enabled edge, then two pulses
    // 16 cycles apart.
    timer_enable = 1;
    for (int i = 0; i < TMAX; i++) begin
      tick();
      chk("t1_pulse", 94'(timer_out), 94'(i == TMAX - 1));
    end
    chk("t1_wrap_count", 94'(timer_count), 94'd0);
    pulses = 0; first_p = -1; second_p = -1;
    for (int i = 0; i < 2 * TMAX; i++) begin
      tick();
      if (timer_out) begin
        pulses++;
        if (first_p < 0) first_p = i; else second_p = i;
      end
    end
    chk("t1_two_pulses", 94'(pulses), 94'd2);
    chk("t1_spacing", 94'(second_p - first_p), 94'(TMAX));

    // Timer test 2: clear at count 9, then hold with enable low.
    repeat (9) tick();
    chk("t2_count9", 94'(timer_count), 94'd9);
    timer_clear = 1;
    tick();
    chk("t2_cleared", 94'(timer_count), 94'd0);
    chk("t2_no_pulse", 94'(timer_out), 94'd0);
    timer_clear = 0;
    repeat (3) tick();
    timer_enable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold", 94'(timer_count), 94'd3);
    end

    // Timer test 3: clear and enable on the terminal count. Clear wins.
    timer_enable = 1;
    repeat (TMAX - 1 - 3) tick();
    chk("t3_at_max", 94'(timer_count), 94'(TMAX - 1));
    timer_clear = 1;
    tick();
    chk("t3_count", 94'(timer_count), 94'd0);
    chk("t3_no_pulse", 94'(timer_out), 94'd0);
    timer_clear = 0;

    // Randomized timer traffic.
    for (int i = 0; i < 300; i++) begin
      timer_clear  = ($urandom_range(0, 7) == 0);
      timer_enable = ($urandom_range(0, 3) != 0);
      tick();
    end
    timer_clear = 0; timer_enable = 0;

`ifdef RECV_MON_CAPTURE_EN
    // Capture: arm, then 4 idle cycles, then trigger with incrementing probe0.
    cap_arm = 1; tick(); cap_arm = 0;
    chk("cap_armed_set", 94'(cap_armed), 94'd1);
    for (int i = 0; i < 4; i++) begin
      rand_probes(1'b0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      rand_probes(1'b1);
      probe0 = 8'hA0 + 8'(i);
      tick();
    end
    chk("cap_done_set", 94'(cap_done), 94'd1);
    chk("cap_armed_clr", 94'(cap_armed), 94'd0);
    chk_rd = 1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      rand_probes(1'($urandom));
      tick();
      chk("rd_probe0", 94'(rd_data[7:0]), 94'(8'hA0 + 8'(a)));
    end
    chk_rd = 0;

    // Reset during capture aborts asynchronously.
    cap_arm = 1; tick(); cap_arm = 0;
    rand_probes(1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      rand_probes(1'($urandom)); tick();
    end
    #2 reset = 1;
    #1;
    chk("async_rst_armed", 94'(cap_armed), 94'd0);
    chk("async_rst_done", 94'(cap_done), 94'd0);
    model_reset();
    reset = 0;

    // Re-arm, retrigger after random pre-trigger traffic, and verify the
    // full capture.
    cap_arm = 1; tick(); cap_arm = 0;
    for (int i = 0; i < 6; i++) begin
      rand_probes(1'b0); tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      rand_probes(i == 0 ? 1'b1 : 1'($urandom));
      cap_arm = 1'($urandom);
      tick();
    end
    cap_arm = 0;
    chk("recap_done", 94'(cap_done), 94'd1);
    chk_rd = 1;
    for (int a = DEPTH - 1; a >= 0; a--) begin
      rd_addr = AW'(a);
      tick();
    end
    rd_addr = '0;
    tick();
    chk_rd = 0;
`else
    // Capture is not built: arm and trigger activity must leave it inert.
    cap_arm = 1;
    for (int i = 0; i < 20; i++) begin
      rand_probes(1'($urandom));
      rd_addr = AW'($urandom);
      tick();
    end
    cap_arm = 0;
    chk("nocap_armed", 94'(cap_armed), 94'd0);
    chk("nocap_done", 94'(cap_done), 94'd0);
    chk("nocap_rd", rd_data, 94'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
